ex_mem_stage: RTL and testbench

- Parametrised, elastic EX/MEM pipeline register for the pipelined LEGv8 core.
- Carries the EX results and the MEM/WB control fields from execute to memory.
- Unlike a plain clocked latch, it has valid/ready handshaking, a one-entry skid buffer for stalls, synchronous flush and bubble gating of control outputs.
- Also drives a registered branch-select (pc_src) to the fetch stage.

---
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the LEGv8 core: valid/ready handshake, optional one-entry
// skid buffer, synchronous flush, bubble-gated control outputs and a registered-field pc_src.
module ex_mem_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int SKID_EN    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     add_result,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     read2,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  branch,
  input  logic                  unc_branch,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_add_result,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_read2,
  output logic                  out_zero,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic                  out_branch,
  output logic                  out_unc_branch,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  out_pc_src,
  output logic [1:0]            occupancy
);

  // ctl bit order: {branch, unc_branch, mem_read, mem_write, reg_write, mem_to_reg}
  typedef struct packed {
    logic [DATA_W-1:0]     add;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd2;
    logic                  zero;
    logic [REG_ADDR_W-1:0] wreg;
    logic [5:0]            ctl;
  } entry_t;

  entry_t in_ent;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   rdy_q;
  logic   in_fire;
  logic   slot_free;

  assign in_ent = {add_result, alu_result, read2, zero, write_reg,
                   branch, unc_branch, mem_read, mem_write, reg_write, mem_to_reg};

  // rdy_q is low during reset and for the first edge after release.
  generate
    if (SKID_EN != 0) begin : g_skid_ready
      assign in_ready = rdy_q;
    end else begin : g_flow_ready
      assign in_ready = rdy_q & (!out_valid_q | out_ready);
    end
  endgenerate

  assign in_fire   = in_valid & in_ready & !flush;
  assign slot_free = !out_valid_q | out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Squash: data payload holds, control is cleared so nothing stale can commit.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_d.ctl    = '0;
      skid_d.ctl   = '0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        if (in_fire) begin
          skid_d = in_ent;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        out_d       = in_ent;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire && (SKID_EN != 0)) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= !skid_valid_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_add_result = out_q.add;
  assign out_alu_result = out_q.alu;
  assign out_read2      = out_q.rd2;
  assign out_zero       = out_q.zero;
  assign out_write_reg  = out_q.wreg;

  // Bubbles must never look like live control to MEM/WB or fetch.
  assign {out_branch, out_unc_branch, out_mem_read,
          out_mem_write, out_reg_write, out_mem_to_reg} = out_q.ctl & {6{out_valid_q}};
  assign out_pc_src = out_valid_q & ((out_q.ctl[5] & out_q.zero) | out_q.ctl[4]);
  assign occupancy  = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic against a FIFO reference model.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [63:0] add_result, alu_result, read2;
  logic        zero;
  logic [4:0]  write_reg;
  logic        branch, unc_branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic        out_valid;
  logic [63:0] out_add_result, out_alu_result, out_read2;
  logic        out_zero;
  logic [4:0]  out_write_reg;
  logic        out_branch, out_unc_branch, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
  logic        out_pc_src;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [63:0] add;
    logic [63:0] alu;
    logic [63:0] rd2;
    logic        zero;
    logic [4:0]  wreg;
    logic [5:0]  ctl;
  } ent_t;

  ent_t cur = '0;
  ent_t shown = '0;
  ent_t q[$];
  bit   rdy_m = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  assign add_result = cur.add;
  assign alu_result = cur.alu;
  assign read2      = cur.rd2;
  assign zero       = cur.zero;
  assign write_reg  = cur.wreg;
  assign {branch, unc_branch, mem_read, mem_write, reg_write, mem_to_reg} = cur.ctl;

  always #5 clock = ~clock;

  ex_mem_stage #(.DATA_W(64), .REG_ADDR_W(5), .SKID_EN(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .add_result(add_result), .alu_result(alu_result), .zero(zero),
    .read2(read2), .write_reg(write_reg),
    .branch(branch), .unc_branch(unc_branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_add_result(out_add_result), .out_alu_result(out_alu_result),
    .out_read2(out_read2), .out_zero(out_zero), .out_write_reg(out_write_reg),
    .out_branch(out_branch), .out_unc_branch(out_unc_branch),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_pc_src(out_pc_src), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] alu, input logic [63:0] add,
                              input logic z, input logic [5:0] ctl);
    ent_t e;
    e      = '0;
    e.alu  = alu;
    e.add  = add;
    e.rd2  = alu ^ 64'h5555_0000_0000_5555;
    e.zero = z;
    e.wreg = alu[4:0];
    e.ctl  = ctl;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.add  = {$urandom, $urandom};
    e.alu  = {$urandom, $urandom};
    e.rd2  = {$urandom, $urandom};
    e.zero = 1'($urandom_range(0, 1));
    e.wreg = 5'($urandom_range(0, 31));
    e.ctl  = 6'($urandom_range(0, 63));
    return e;
  endfunction

  task automatic check_outputs();
    bit   v;
    logic exp_pc;
    v      = (q.size() > 0);
    exp_pc = v && ((shown.ctl[5] && shown.zero) || shown.ctl[4]);
    check("out_valid", 64'(out_valid), 64'(v));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("out_alu", out_alu_result, shown.alu);
    check("out_add", out_add_result, shown.add);
    check("out_read2", out_read2, shown.rd2);
    check("out_zero", 64'(out_zero), 64'(shown.zero));
    check("out_wreg", 64'(out_write_reg), 64'(shown.wreg));
    check("out_ctl", 64'({out_branch, out_unc_branch, out_mem_read, out_mem_write,
                          out_reg_write, out_mem_to_reg}), 64'(v ? shown.ctl : 6'd0));
    check("out_pc_src", 64'(out_pc_src), 64'(exp_pc));
  endtask

  // One clock: compare in_ready, advance the FIFO model, compare outputs after the edge.
  task automatic step();
    bit mready, fire_in, fire_out;
    mready   = rdy_m && (q.size() < 2);
    check("in_ready", 64'(in_ready), 64'(mready));
    fire_in  = in_valid && mready && !flush;
    fire_out = (q.size() > 0) && out_ready;
    @(posedge clock);
    if (flush) begin
      q.delete();
    end else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(cur);
    end
    rdy_m = 1'b1;
    if (q.size() > 0) shown = q[0];
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit ordy, input bit fl, input ent_t e);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    cur       = e;
  endtask

  initial begin
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check_outputs();
    #10 reset_n = 1'b1;
    step();

    // Streaming
    drive(1, 1, 0, mk(64'h10, 64'h0, 0, 6'd0)); step();
    check("stream_10", out_alu_result, 64'h10);
    drive(1, 1, 0, mk(64'h20, 64'h0, 0, 6'd0)); step();
    check("stream_20", out_alu_result, 64'h20);
    drive(1, 1, 0, mk(64'h30, 64'h0, 0, 6'd0)); step();
    check("stream_30", out_alu_result, 64'h30);
    check("stream_occ", 64'(occupancy), 64'd1);
    drive(0, 1, 0, '0); step();

    // Stall fill then ordered drain
    drive(1, 0, 0, mk(64'hA, 64'h0, 0, 6'd0)); step();
    drive(1, 0, 0, mk(64'hB, 64'h0, 0, 6'd0)); step();
    check("fill_occ", 64'(occupancy), 64'd2);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_head", out_alu_result, 64'hA);
    drive(0, 1, 0, '0); step();
    check("drain_second", out_alu_result, 64'hB);
    check("drain_in_ready", 64'(in_ready), 64'd1);
    step();

    // Branch select
    drive(1, 1, 0, mk(64'h1, 64'h400, 1, 6'b100000)); step();
    check("br_taken", 64'(out_pc_src), 64'd1);
    check("br_target", out_add_result, 64'h400);
    drive(1, 1, 0, mk(64'h2, 64'h404, 0, 6'b100000)); step();
    check("br_not_taken", 64'(out_pc_src), 64'd0);
    drive(1, 1, 0, mk(64'h3, 64'h408, 0, 6'b010000)); step();
    check("unc_taken", 64'(out_pc_src), 64'd1);
    drive(0, 1, 0, '0); step();

    // Flush with two held entries and a live input
    drive(1, 0, 0, mk(64'hC1, 64'h0, 1, 6'b100100)); step();
    drive(1, 0, 0, mk(64'hC2, 64'h0, 0, 6'b000110)); step();
    check("pre_flush_occ", 64'(occupancy), 64'd2);
    drive(1, 0, 1, mk(64'hC3, 64'h0, 0, 6'b000010)); step();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_reg_write", 64'(out_reg_write), 64'd0);
    check("flush_mem_write", 64'(out_mem_write), 64'd0);
    check("flush_pc_src", 64'(out_pc_src), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    drive(0, 1, 0, '0); step();

    // Bubble gating
    drive(1, 1, 0, mk(64'hBE, 64'h0, 0, 6'b000100)); step();
    check("bubble_live_mw", 64'(out_mem_write), 64'd1);
    drive(0, 1, 0, '0); step();
    step();
    check("bubble_mw", 64'(out_mem_write), 64'd0);
    check("bubble_rd2_hold", out_read2, 64'hBE ^ 64'h5555_0000_0000_5555);

    // Async reset mid-stall
    drive(1, 0, 0, mk(64'hD1, 64'h0, 1, 6'b110011)); step();
    drive(1, 0, 0, mk(64'hD2, 64'h0, 1, 6'b110011)); step();
    check("prerst_occ", 64'(occupancy), 64'd2);
    drive(0, 0, 0, '0);
    #1 reset_n = 1'b0;
    q.delete();
    shown = '0;
    rdy_m = 1'b0;
    #1;
    check_outputs();
    #1 reset_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 60),
            1'($urandom_range(0, 99) < 5), rnd_ent());
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
